// File: rtl/sat_engine_unloader.sv
// Read-back controller for one sat_engine bin: snapshots var/level states on start,
// reads every clause row, then streams clauses, var states and level states out.
module sat_engine_unloader #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_IDX        = 4,
    parameter int WIDTH_DATA       = 19
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_unload_i,
    input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
    output logic                                 busy_o,
    output logic                                 done_unload_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    input  logic [NUM_VARS*2-1:0]                clause_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic                                 wr_valid_o,
    input  logic                                 wr_ready_i,
    output logic [1:0]                           wr_type_o,
    output logic [WIDTH_BIN_ID-1:0]              wr_bin_id_o,
    output logic [WIDTH_IDX-1:0]                 wr_index_o,
    output logic [WIDTH_DATA-1:0]                wr_data_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CREQ, S_CCAP, S_COUT, S_VOUT, S_LOUT, S_DONE
    } state_e;

    localparam logic [WIDTH_IDX-1:0] LAST_CLAUSE = WIDTH_IDX'(NUM_CLAUSES - 1);
    localparam logic [WIDTH_IDX-1:0] LAST_VAR    = WIDTH_IDX'(NUM_VARS - 1);
    localparam logic [WIDTH_IDX-1:0] LAST_LVL    = WIDTH_IDX'(NUM_LVLS - 1);

    state_e                                 state_q, state_d;
    logic [WIDTH_IDX-1:0]                   idx_q, idx_d;
    logic [WIDTH_BIN_ID-1:0]                binId_q, binId_d;
    logic [NUM_VARS*2-1:0]                  clause_q, clause_d;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   varsSnap_q, varsSnap_d;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvlsSnap_q, lvlsSnap_d;
    logic [WIDTH_VAR_STATES-1:0]            varSel;
    logic [WIDTH_LVL_STATES-1:0]            lvlSel;
    logic                                   handshake;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            binId_q    <= '0;
            clause_q   <= '0;
            varsSnap_q <= '0;
            lvlsSnap_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            binId_q    <= binId_d;
            clause_q   <= clause_d;
            varsSnap_q <= varsSnap_d;
            lvlsSnap_q <= lvlsSnap_d;
        end
    end

    assign handshake = wr_valid_o & wr_ready_i;

    // One index counter is reused for clause rows, var entries and level entries.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        binId_d    = binId_q;
        clause_d   = clause_q;
        varsSnap_d = varsSnap_q;
        lvlsSnap_d = lvlsSnap_q;
        case (state_q)
            S_IDLE: begin
                if (start_unload_i) begin
                    binId_d    = bin_id_i;
                    varsSnap_d = vars_states_i;
                    lvlsSnap_d = lvl_states_i;
                    idx_d      = '0;
                    state_d    = S_CREQ;
                end
            end
            S_CREQ: state_d = S_CCAP;
            S_CCAP: begin
                clause_d = clause_i;
                state_d  = S_COUT;
            end
            S_COUT: begin
                if (handshake) begin
                    if (idx_q == LAST_CLAUSE) begin
                        idx_d   = '0;
                        state_d = S_VOUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_CREQ;
                    end
                end
            end
            S_VOUT: begin
                if (handshake) begin
                    if (idx_q == LAST_VAR) begin
                        idx_d   = '0;
                        state_d = S_LOUT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LOUT: begin
                if (handshake) begin
                    if (idx_q == LAST_LVL) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        varSel = '0;
        lvlSel = '0;
        for (int j = 0; j < NUM_VARS; j++) begin
            if (idx_q == WIDTH_IDX'(j)) varSel = varsSnap_q[j*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
        end
        for (int j = 0; j < NUM_LVLS; j++) begin
            if (idx_q == WIDTH_IDX'(j)) lvlSel = lvlsSnap_q[j*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
        end
    end

    // Outputs are decoded from registered state only, so they hold through a stall.
    always_comb begin
        busy_o        = (state_q != S_IDLE);
        done_unload_o = (state_q == S_DONE);
        rd_carray_o   = '0;
        wr_valid_o    = 1'b0;
        wr_type_o     = 2'd0;
        wr_data_o     = '0;
        case (state_q)
            S_CREQ: begin
                rd_carray_o = NUM_CLAUSES'(1) << idx_q;
                wr_data_o   = WIDTH_DATA'(clause_q);
            end
            S_CCAP: wr_data_o = WIDTH_DATA'(clause_q);
            S_COUT: begin
                wr_valid_o = 1'b1;
                wr_data_o  = WIDTH_DATA'(clause_q);
            end
            S_VOUT: begin
                wr_valid_o = 1'b1;
                wr_type_o  = 2'd1;
                wr_data_o  = WIDTH_DATA'(varSel);
            end
            S_LOUT: begin
                wr_valid_o = 1'b1;
                wr_type_o  = 2'd2;
                wr_data_o  = WIDTH_DATA'(lvlSel);
            end
            default: ;
        endcase
    end

    assign wr_bin_id_o = binId_q;
    assign wr_index_o  = idx_q;

endmodule

// File: tb/tb_sat_engine_unloader.sv
// Randomized bench for sat_engine_unloader: an engine clause model feeds the DUT and
// an expected-entry queue built from the start-time inputs scores every write.
module tb_sat_engine_unloader;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int NL = 8;
    localparam int WB = 10;
    localparam int WV = 19;
    localparam int WL = 11;
    localparam int WI = 4;
    localparam int WD = 19;
    localparam int TOTAL = NC + NV + NL;

    typedef struct {
        int kind;
        int index;
        int data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_unload_i;
    logic [WB-1:0]     bin_id_i;
    logic              busy_o;
    logic              done_unload_o;
    logic [NC-1:0]     rd_carray_o;
    logic [2*NV-1:0]   clause_i = '0;
    logic [WV*NV-1:0]  vars_states_i;
    logic [WL*NL-1:0]  lvl_states_i;
    logic              wr_valid_o;
    logic              wr_ready_i;
    logic [1:0]        wr_type_o;
    logic [WB-1:0]     wr_bin_id_o;
    logic [WI-1:0]     wr_index_o;
    logic [WD-1:0]     wr_data_o;

    logic [2*NV-1:0]   clauseTable [NC];
    entry_t            expQ [$];
    int                checkCount = 0;
    int                passCount  = 0;

    logic [WB-1:0]     patBin;
    logic [WV*NV-1:0]  patVars;
    logic [WL*NL-1:0]  patLvls;

    sat_engine_unloader dut (
        .clk            (clk),
        .rst            (rst),
        .start_unload_i (start_unload_i),
        .bin_id_i       (bin_id_i),
        .busy_o         (busy_o),
        .done_unload_o  (done_unload_o),
        .rd_carray_o    (rd_carray_o),
        .clause_i       (clause_i),
        .vars_states_i  (vars_states_i),
        .lvl_states_i   (lvl_states_i),
        .wr_valid_o     (wr_valid_o),
        .wr_ready_i     (wr_ready_i),
        .wr_type_o      (wr_type_o),
        .wr_bin_id_o    (wr_bin_id_o),
        .wr_index_o     (wr_index_o),
        .wr_data_o      (wr_data_o)
    );

    always #5 clk = ~clk;

    // The engine returns the selected clause row one cycle after the select.
    function automatic logic [2*NV-1:0] rowLookup(input logic [NC-1:0] sel);
        logic [2*NV-1:0] row;
        row = '0;
        for (int r = 0; r < NC; r++) if (sel[r]) row = clauseTable[r];
        return row;
    endfunction

    always @(posedge clk) clause_i <= rowLookup(rd_carray_o);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    endtask

    task automatic randomPattern();
        for (int r = 0; r < NC; r++) clauseTable[r] = (2*NV)'($urandom);
        for (int j = 0; j < NV; j++) patVars[j*WV +: WV] = WV'($urandom);
        for (int j = 0; j < NL; j++) patLvls[j*WL +: WL] = WL'($urandom);
        patBin = WB'($urandom);
    endtask

    // readyMode: 0 = always ready, 1 = repeating 0,0,1, 2 = random.
    // changeAt / restartAt / rstAt are cycles after the start edge (0 = unused).
    task automatic applyStimulus(input int readyMode, input int changeAt, input int restartAt, input int rstAt);
        int            cyc;
        int            hs;
        int            rdPulses;
        int            doneCount;
        int            doneCyc;
        bit            running;
        bit            prevStall;
        logic [31:0]   prevType, prevIdx, prevData;
        logic [NC-1:0] prevRd;
        entry_t        e;

        expQ.delete();
        for (int r = 0; r < NC; r++) expQ.push_back('{0, r, int'(clauseTable[r])});
        for (int j = 0; j < NV; j++) expQ.push_back('{1, j, int'(patVars[j*WV +: WV])});
        for (int j = 0; j < NL; j++) expQ.push_back('{2, j, int'(patLvls[j*WL +: WL])});

        @(negedge clk);
        bin_id_i       = patBin;
        vars_states_i  = patVars;
        lvl_states_i   = patLvls;
        start_unload_i = 1'b1;
        wr_ready_i     = 1'b0;
        @(negedge clk);
        start_unload_i = 1'b0;

        cyc = 1; hs = 0; rdPulses = 0; doneCount = 0; doneCyc = 0;
        running = 1'b1; prevStall = 1'b0; prevRd = '0;
        prevType = '0; prevIdx = '0; prevData = '0;
        while (running) begin
            case (readyMode)
                0:       wr_ready_i = 1'b1;
                1:       wr_ready_i = (cyc % 3 == 2);
                default: wr_ready_i = 1'($urandom_range(0, 1));
            endcase
            start_unload_i = (restartAt != 0 && cyc == restartAt);
            if (changeAt != 0 && cyc == changeAt) begin
                vars_states_i = '1;
                lvl_states_i  = '1;
            end

            if (rstAt != 0 && cyc == rstAt) begin
                rst = 1'b1;
                #1;
                checkOutput("rstBusy", 32'(busy_o), 0);
                checkOutput("rstValid", 32'(wr_valid_o), 0);
                checkOutput("rstData", 32'(wr_data_o), 0);
                @(negedge clk);
                checkOutput("rstRdcNext", 32'(rd_carray_o), 0);
                checkOutput("rstDoneNext", 32'(done_unload_o), 0);
                checkOutput("rstIndexNext", 32'(wr_index_o), 0);
                checkOutput("rstBinNext", 32'(wr_bin_id_o), 0);
                checkOutput("rstNoDone", 32'(doneCount), 0);
                rst = 1'b0;
                start_unload_i = 1'b0;
                return;
            end

            if (readyMode == 0) begin
                checkOutput("rdcTiming", 32'(rd_carray_o),
                            (cyc % 3 == 1 && cyc < 3*NC) ? (32'd1 << (cyc / 3)) : 32'd0);
                checkOutput("validTiming", 32'(wr_valid_o),
                            32'((cyc <= 3*NC && cyc % 3 == 0) || (cyc > 3*NC && cyc <= 3*NC + NV + NL)));
                checkOutput("doneTiming", 32'(done_unload_o), 32'(cyc == 3*NC + NV + NL + 1));
            end else if (rd_carray_o != '0) begin
                checkOutput("rdcOrder", 32'(rd_carray_o), 32'd1 << rdPulses);
                checkOutput("rdcSingle", 32'(prevRd), 0);
            end
            if (rd_carray_o != '0) rdPulses++;
            prevRd = rd_carray_o;

            if (prevStall) begin
                checkOutput("stallValid", 32'(wr_valid_o), 1);
                checkOutput("stallType", 32'(wr_type_o), prevType);
                checkOutput("stallIndex", 32'(wr_index_o), prevIdx);
                checkOutput("stallData", 32'(wr_data_o), prevData);
            end
            prevStall = wr_valid_o && !wr_ready_i;
            prevType  = 32'(wr_type_o);
            prevIdx   = 32'(wr_index_o);
            prevData  = 32'(wr_data_o);

            if (wr_valid_o && wr_ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraEntry", 32'(expQ.size()), 1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("entryType", 32'(wr_type_o), 32'(e.kind));
                    checkOutput("entryIndex", 32'(wr_index_o), 32'(e.index));
                    checkOutput("entryData", 32'(wr_data_o), 32'(e.data));
                    checkOutput("entryBin", 32'(wr_bin_id_o), 32'(patBin));
                end
                hs++;
            end

            if (done_unload_o) begin
                doneCount++;
                if (doneCyc == 0) begin
                    doneCyc = cyc;
                    checkOutput("doneEntries", 32'(hs), TOTAL);
                    checkOutput("doneValid", 32'(wr_valid_o), 0);
                end
            end

            if (doneCyc != 0 && cyc > doneCyc) begin
                checkOutput("idleBusy", 32'(busy_o), 0);
                checkOutput("idleValid", 32'(wr_valid_o), 0);
                checkOutput("idleDone", 32'(done_unload_o), 0);
                if (cyc >= doneCyc + 3) running = 1'b0;
            end else begin
                checkOutput("busy", 32'(busy_o), 1);
            end

            if (running && doneCyc == 0 && cyc >= 400) begin
                checkOutput("doneTimeout", 32'(done_unload_o), 1);
                running = 1'b0;
            end

            if (running) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("hsCount", 32'(hs), TOTAL);
        checkOutput("doneCount", 32'(doneCount), 1);
        checkOutput("rdcCount", 32'(rdPulses), NC);
    endtask

    initial begin
        rst            = 1'b1;
        start_unload_i = 1'b0;
        bin_id_i       = '0;
        vars_states_i  = '0;
        lvl_states_i   = '0;
        wr_ready_i     = 1'b0;
        for (int r = 0; r < NC; r++) clauseTable[r] = 16'h0100 + 16'(r);

        @(negedge clk);
        checkOutput("resetBusy", 32'(busy_o), 0);
        checkOutput("resetDone", 32'(done_unload_o), 0);
        checkOutput("resetRdc", 32'(rd_carray_o), 0);
        checkOutput("resetValid", 32'(wr_valid_o), 0);
        checkOutput("resetType", 32'(wr_type_o), 0);
        checkOutput("resetBin", 32'(wr_bin_id_o), 0);
        checkOutput("resetIndex", 32'(wr_index_o), 0);
        checkOutput("resetData", 32'(wr_data_o), 0);
        rst = 1'b0;

        patBin = 10'h05;
        for (int j = 0; j < NV; j++) patVars[j*WV +: WV] = 19'h1_2345;
        for (int j = 0; j < NL; j++) patLvls[j*WL +: WL] = WL'(j);
        $display("[TB] directed unload, ready high");
        applyStimulus(0, 0, 0, 0);
        $display("[TB] directed unload, ready 0,0,1");
        applyStimulus(1, 0, 0, 0);

        $display("[TB] engine state changes after start");
        randomPattern();
        applyStimulus(0, 2, 0, 0);
        $display("[TB] second start while busy");
        randomPattern();
        applyStimulus(0, 0, 10, 0);
        $display("[TB] reset mid-clause, then a full unload");
        randomPattern();
        applyStimulus(0, 0, 0, 15);
        randomPattern();
        applyStimulus(0, 0, 0, 0);

        $display("[TB] random ready back-pressure");
        for (int t = 0; t < 4; t++) begin
            randomPattern();
            applyStimulus(2, (t == 1) ? 5 : 0, (t == 2) ? 7 : 0, 0);
        end
        randomPattern();
        applyStimulus(1, 4, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
